// File: rtl/swerv_eth_pkg.sv
// Shared constants and types for the SweRV Ethernet receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package swerv_eth_pkg;

  // Register offsets, decoded from adr[5:2]
  localparam logic [3:0] REG_STATUS = 4'h0;
  localparam logic [3:0] REG_DATA   = 4'h1;
  localparam logic [3:0] REG_CTRL   = 4'h2;

  // CTRL register bit positions
  localparam int CTRL_RELEASE = 0;
  localparam int CTRL_CLR_CNT = 1;

  localparam int          ETH_HDR_LEN = 14;
  localparam logic [47:0] MAC_BCAST   = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    ST_RESYNC,
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_DROP
  } rx_state_e;

  // STATUS register layout
  typedef struct packed {
    logic [7:0] err_cnt;
    logic [7:0] drop_cnt;
    logic [7:0] length;
    logic [5:0] rsvd;
    logic       trunc;
    logic       pkt_valid;
  } rx_status_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/eth_rx_buf.sv
// eth_rx_buf: byte-write payload RAM with a 4-byte little-endian read window.
// Latency: write lands on the clock edge; read is combinational from rd_ptr.
// Backpressure: none; bytes at or beyond length read as zero.
// Ports: clk_mac; wr_en/wr_addr/wr_data byte write; rd_ptr/length/rd_data read window.
module eth_rx_buf
  import swerv_eth_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_mac,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW:0]   rd_ptr,
  input  logic [AW:0]   length,
  output logic [31:0]   rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk_mac) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // rd_ptr never exceeds DEPTH, so rd_ptr+3 still fits in AW+1 bits; any
  // lane that would wrap the RAM index is at or past length and reads zero.
  for (genvar k = 0; k < 4; k++) begin : g_lane
    logic [AW:0] idx;
    assign idx               = rd_ptr + (AW+1)'(k);
    assign rd_data[8*k +: 8] = (idx < length) ? mem[idx[AW-1:0]] : 8'h00;
  end

endmodule

// File: rtl/swerv_eth_rx.sv
// swerv_eth_rx: EtherType-filtered one-frame receive buffer with Wishbone slave and irq.
// Latency: pkt_valid/rx_irq rise the cycle after the completing tlast beat; Wishbone ack one cycle after cyc&stb.
// Backpressure: none on the rx stream (frames arriving while a payload is held are dropped and counted).
// Ports: clk_mac, rst_n (synchronous, active-low); rx_axis_mac_* byte stream in;
//        wb_eth_rx_* Wishbone slave (STATUS 0x0, DATA 0x4, CTRL 0x8); rx_irq level high while pkt_valid.
// Option: define SWERV_ETH_RX_MAC_FILTER_EN to also require broadcast or LOCAL_MAC as destination.
module swerv_eth_rx
  import swerv_eth_pkg::*;
#(
  parameter int          BUF_DEPTH  = 64,
  parameter logic [15:0] ETH_TYPE   = 16'hEBEB,
  parameter int          RESYNC_GAP = 64,
  parameter logic [47:0] LOCAL_MAC  = 48'h000000000000
) (
  input  logic        clk_mac,
  input  logic        rst_n,
  input  logic [7:0]  rx_axis_mac_tdata,
  input  logic        rx_axis_mac_tvalid,
  input  logic        rx_axis_mac_tlast,
  input  logic        rx_axis_mac_tuser,
  input  logic [31:0] wb_eth_rx_adr_i,
  input  logic [31:0] wb_eth_rx_dat_i,
  input  logic [3:0]  wb_eth_rx_sel_i,
  input  logic        wb_eth_rx_we_i,
  input  logic        wb_eth_rx_stb_i,
  input  logic        wb_eth_rx_cyc_i,
  output logic [31:0] wb_eth_rx_dat_o,
  output logic        wb_eth_rx_ack_o,
  output logic        wb_eth_rx_err_o,
  output logic        wb_eth_rx_rty_o,
  output logic        rx_irq
);

  localparam int          AW       = $clog2(BUF_DEPTH);
  localparam int          GW       = $clog2(RESYNC_GAP + 1);
  localparam logic [AW:0] DEPTH_L  = (AW+1)'(BUF_DEPTH);
  localparam logic [3:0]  HDR_LAST = 4'(ETH_HDR_LEN - 1);

  rx_state_e     state, state_nxt;
  logic [3:0]    hdr_idx;
  logic [GW-1:0] gap_cnt;
  logic [7:0]    prev_byte;
  logic          err_seen, trunc_pend;
  logic [AW:0]   wr_idx, length, rd_ptr, len_fin;
  logic          pkt_valid, trunc, trunc_fin;
  logic [7:0]    drop_cnt, err_cnt;
  logic          beat, bad, et_match, dst_reject, buf_we;
  logic          ev_complete, ev_err, ev_drop;
  logic          wb_sel, wb_ack, wb_fire, rd_adv, do_release, do_clear;
  logic [3:0]    reg_idx;
  logic [31:0]   buf_rdata, rd_mux, wb_dat;
  rx_status_t    status;
  logic          unused_ok;

  assign beat     = rx_axis_mac_tvalid;
  assign bad      = err_seen | rx_axis_mac_tuser;
  // prev_byte holds byte 12 when byte 13 is on the bus
  assign et_match = ({prev_byte, rx_axis_mac_tdata} == ETH_TYPE);
  assign buf_we   = (state == ST_PAYLOAD) && beat && (wr_idx < DEPTH_L);

`ifdef SWERV_ETH_RX_MAC_FILTER_EN
  logic [39:0] dst;
  logic [47:0] dst_full;
  always_ff @(posedge clk_mac) begin
    if (!rst_n)    dst <= '0;
    else if (beat) dst <= {dst[31:0], rx_axis_mac_tdata};
  end
  assign dst_full   = {dst, rx_axis_mac_tdata};
  assign dst_reject = (hdr_idx == 4'd5) && (dst_full != MAC_BCAST) && (dst_full != LOCAL_MAC);
`else
  assign dst_reject = 1'b0;
`endif

  // Next-state and per-frame events
  always_comb begin
    state_nxt   = state;
    ev_complete = 1'b0;
    ev_err      = 1'b0;
    ev_drop     = 1'b0;
    len_fin     = '0;
    trunc_fin   = 1'b0;
    case (state)
      ST_RESYNC: begin
        if ((beat && rx_axis_mac_tlast) || (!beat && gap_cnt == GW'(RESYNC_GAP - 1)))
          state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (beat) begin
          if (rx_axis_mac_tlast) ev_err = 1'b1;          // 1-byte runt
          else if (pkt_valid) begin
            ev_drop   = 1'b1;
            state_nxt = ST_DROP;
          end else state_nxt = ST_HDR;
        end
      end
      ST_HDR: begin
        if (beat) begin
          if (hdr_idx == HDR_LAST) begin
            if (rx_axis_mac_tlast) begin
              state_nxt = ST_IDLE;
              if (bad)           ev_err      = 1'b1;
              else if (et_match) ev_complete = 1'b1;     // zero-length payload
            end else begin
              state_nxt = et_match ? ST_PAYLOAD : ST_DROP;
            end
          end else if (rx_axis_mac_tlast) begin
            state_nxt = ST_IDLE;
            ev_err    = 1'b1;
          end else if (dst_reject) begin
            state_nxt = ST_DROP;
          end
        end
      end
      ST_PAYLOAD: begin
        if (beat && rx_axis_mac_tlast) begin
          state_nxt = ST_IDLE;
          if (bad) ev_err = 1'b1;
          else begin
            ev_complete = 1'b1;
            // the tlast byte itself counts toward the payload
            len_fin     = wr_idx + {{AW{1'b0}}, buf_we};
            trunc_fin   = trunc_pend | ~buf_we;
          end
        end
      end
      ST_DROP: begin
        if (beat && rx_axis_mac_tlast) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_RESYNC;
    endcase
  end

  // Wishbone decode; effects land on the ack cycle
  assign wb_sel     = wb_eth_rx_cyc_i & wb_eth_rx_stb_i;
  assign wb_fire    = wb_ack & wb_sel;
  assign reg_idx    = wb_eth_rx_adr_i[5:2];
  assign rd_adv     = wb_fire & ~wb_eth_rx_we_i & (reg_idx == REG_DATA);
  assign do_release = wb_fire & wb_eth_rx_we_i & (reg_idx == REG_CTRL) & wb_eth_rx_dat_i[CTRL_RELEASE];
  assign do_clear   = wb_fire & wb_eth_rx_we_i & (reg_idx == REG_CTRL) & wb_eth_rx_dat_i[CTRL_CLR_CNT];

  always_comb begin
    status.err_cnt   = err_cnt;
    status.drop_cnt  = drop_cnt;
    status.length    = 8'(length);
    status.rsvd      = '0;
    status.trunc     = trunc;
    status.pkt_valid = pkt_valid;
  end

  always_comb begin
    rd_mux = '0;
    if (!wb_eth_rx_we_i) begin
      case (reg_idx)
        REG_STATUS: rd_mux = status;
        REG_DATA:   rd_mux = buf_rdata;
        default:    rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clk_mac) begin
    if (!rst_n) begin
      state      <= ST_RESYNC;
      hdr_idx    <= '0;
      gap_cnt    <= '0;
      prev_byte  <= '0;
      err_seen   <= 1'b0;
      trunc_pend <= 1'b0;
      wr_idx     <= '0;
      pkt_valid  <= 1'b0;
      trunc      <= 1'b0;
      length     <= '0;
      rd_ptr     <= '0;
      drop_cnt   <= '0;
      err_cnt    <= '0;
      wb_ack     <= 1'b0;
      wb_dat     <= '0;
    end else begin
      state <= state_nxt;
      if (beat) prev_byte <= rx_axis_mac_tdata;

      // IDLE consumes byte 0, so HDR starts counting at 1
      if (state == ST_IDLE)            hdr_idx <= 4'd1;
      else if (state == ST_HDR && beat) hdr_idx <= hdr_idx + 4'd1;

      gap_cnt <= (state == ST_RESYNC && !beat) ? gap_cnt + 1'b1 : '0;

      // Sticky per-frame tuser, cleared at frame end and while resyncing
      if (state == ST_RESYNC) err_seen <= 1'b0;
      else if (beat)          err_seen <= rx_axis_mac_tlast ? 1'b0 : (err_seen | rx_axis_mac_tuser);

      if (state != ST_PAYLOAD) begin
        wr_idx     <= '0;
        trunc_pend <= 1'b0;
      end else begin
        if (buf_we)             wr_idx     <= wr_idx + 1'b1;
        else if (beat)          trunc_pend <= 1'b1;
      end

      // Completion outranks a same-cycle release
      if (ev_complete) begin
        pkt_valid <= 1'b1;
        length    <= len_fin;
        trunc     <= trunc_fin;
        rd_ptr    <= '0;
      end else if (do_release) begin
        pkt_valid <= 1'b0;
        trunc     <= 1'b0;
        rd_ptr    <= '0;
      end else if (rd_adv) begin
        rd_ptr <= (rd_ptr >= DEPTH_L - (AW+1)'(4)) ? DEPTH_L : rd_ptr + (AW+1)'(4);
      end

      // Clear outranks a same-cycle increment
      if (do_clear)     drop_cnt <= '0;
      else if (ev_drop) drop_cnt <= sat_inc8(drop_cnt);
      if (do_clear)     err_cnt  <= '0;
      else if (ev_err)  err_cnt  <= sat_inc8(err_cnt);

      wb_ack <= wb_sel & ~wb_ack;
      wb_dat <= (wb_sel & ~wb_ack) ? rd_mux : '0;
    end
  end

  eth_rx_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk_mac (clk_mac),
    .wr_en   (buf_we),
    .wr_addr (wr_idx[AW-1:0]),
    .wr_data (rx_axis_mac_tdata),
    .rd_ptr  (rd_ptr),
    .length  (length),
    .rd_data (buf_rdata)
  );

  assign wb_eth_rx_dat_o = wb_dat;
  assign wb_eth_rx_ack_o = wb_ack;
  assign wb_eth_rx_err_o = 1'b0;
  assign wb_eth_rx_rty_o = 1'b0;
  assign rx_irq          = pkt_valid;

  // Full-word access only: byte selects and low/high address bits carry no meaning
  assign unused_ok = ^{wb_eth_rx_sel_i, wb_eth_rx_adr_i[31:6], wb_eth_rx_adr_i[1:0],
                       wb_eth_rx_dat_i[31:2], LOCAL_MAC};

endmodule
